// File: rtl/dma_rr_arbiter_pkg.sv
// Shared types and constants for the DMA round-robin arbiter.
//   arb_state_e : two-state arbiter FSM encoding (IDLE, BUSY)
//   WDOG_CNT_W  : width of the optional BUSY-cycle watchdog counter
package netdma_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int WDOG_CNT_W = 16;

endpackage

// File: rtl/dma_rr_arbiter_if.sv
// Request/grant bundle between DMA requesters and the round-robin arbiter.
//   req_i     : per-requester request level (N = 2**RANGE bits)
//   done_i    : last-beat pulse from the granted requester
//   gnt_o     : one-hot grant, zero when idle
//   gnt_idx_o : binary index of the current or last grant
//   busy_o    : a grant is held
//   timeout_o : one-cycle pulse on a watchdog release
// master = requester side, slave = arbiter side.
interface dma_rr_arbiter_if #(
    parameter int RANGE = 2
);
    localparam int N = 2**RANGE;

    logic [N-1:0]     req_i;
    logic             done_i;
    logic [N-1:0]     gnt_o;
    logic [RANGE-1:0] gnt_idx_o;
    logic             busy_o;
    logic             timeout_o;

    modport master (
        output req_i, done_i,
        input  gnt_o, gnt_idx_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, done_i,
        output gnt_o, gnt_idx_o, busy_o, timeout_o
    );
endinterface

// File: rtl/dma_rr_arbiter_dec.sv
// Binary-to-one-hot grant decoder.
//   i_idx    : binary index (RANGE bits)
//   i_en     : decode enable; output is all-zero when low
//   o_onehot : one-hot decode of i_idx (2**RANGE bits)
module dma_rr_arbiter_dec #(
    parameter int RANGE = 2
) (
    input  logic [RANGE-1:0]    i_idx,
    input  logic                i_en,
    output logic [2**RANGE-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter for N = 2**RANGE DMA requesters.
// A grant is held until done_i or until the granted requester drops its
// request; every release is followed by one idle bubble cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dma_rr_arbiter_if.slave (req_i, done_i, gnt_o, gnt_idx_o,
//           busy_o, timeout_o)
// Optional feature: define DMA_RR_ARBITER_WATCHDOG_EN to compile in a
// BUSY-cycle watchdog that forces a release after TIMEOUT cycles and pulses
// timeout_o. Without it timeout_o is tied low and TIMEOUT is unused.
module dma_rr_arbiter
    import netdma_arb_pkg::*;
#(
    parameter int RANGE   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    dma_rr_arbiter_if.slave    bus
);

    localparam int N = 2**RANGE;

    arb_state_e       r_state;
    logic [RANGE-1:0] r_gnt_idx;
    logic [RANGE-1:0] r_last_idx;
    logic             r_busy;

    logic [RANGE-1:0] w_pick;
    logic             w_found;
    logic             w_release;
    logic             w_wdog_fire;
    logic [N-1:0]     w_gnt;

    // Scan upward from the slot after the last grant; k = N lands on the
    // last grantee itself, so it only wins when nobody else is requesting.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && bus.req_i[r_last_idx + RANGE'(k)]) begin
                w_pick  = r_last_idx + RANGE'(k);
                w_found = 1'b1;
            end
        end
    end

    // done_i and an abandon together still produce a single release.
    assign w_release = bus.done_i || !bus.req_i[r_gnt_idx];

`ifdef DMA_RR_ARBITER_WATCHDOG_EN
    logic [WDOG_CNT_W-1:0] r_wdog_cnt;
    logic                  r_timeout;

    assign w_wdog_fire = (r_wdog_cnt == WDOG_CNT_W'(TIMEOUT - 1));

    // Counter rests at zero in IDLE, so it starts at zero on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= (r_state == BUSY) && w_wdog_fire && !w_release;
            if (r_state == IDLE) r_wdog_cnt <= '0;
            else                 r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign w_wdog_fire   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt_idx  <= '0;
            r_last_idx <= RANGE'(N - 1);
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BUSY;
                        r_gnt_idx  <= w_pick;
                        r_last_idx <= w_pick;
                        r_busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_release || w_wdog_fire) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    dma_rr_arbiter_dec #(.RANGE(RANGE)) u_dec (
        .i_idx    (r_gnt_idx),
        .i_en     (r_busy),
        .o_onehot (w_gnt)
    );

    assign bus.gnt_o     = w_gnt;
    assign bus.gnt_idx_o = r_gnt_idx;
    assign bus.busy_o    = r_busy;

endmodule

// File: doc/dma_rr_arbiter.md
DMA_RR_ARBITER -- requirements
Module: dma_rr_arbiter

Interface
REQ-001 SHALL have parameter RANGE, default 2, meaning log2 of the requester count (N = 2**RANGE).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of BUSY cycles per grant when the watchdog is compiled in; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_i, input, N bits: per-requester request level.
REQ-006 SHALL have port done_i, input, 1 bit: pulse from the granted requester on its last transfer beat.
REQ-007 SHALL have port gnt_o, output, N bits: one-hot grant, or all-zero when no grant.
REQ-008 SHALL have port gnt_idx_o, output, RANGE bits: binary index of the current or last grant.
REQ-009 SHALL have port busy_o, output, 1 bit: high while any grant is held.
REQ-010 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on a watchdog release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE with req_i != 0, it SHALL pick the first set bit scanning upward from (last_idx+1) mod N with wrap-around, register it into gnt_idx_o, and enter BUSY.
REQ-013 Grant latency SHALL be exactly 1 cycle from the req_i sample to gnt_o/busy_o high.
REQ-014 In BUSY, gnt_o SHALL equal the one-hot decode of gnt_idx_o and SHALL be held stable.
REQ-015 In BUSY, done_i high SHALL return the FSM to IDLE; gnt_o SHALL drop the next cycle.
REQ-016 In BUSY, req_i[gnt_idx_o] low SHALL release the grant the same way as done_i (abandon).
REQ-017 done_i and an abandon in the same cycle SHALL cause exactly one release.
REQ-018 done_i in IDLE SHALL be ignored.
REQ-019 After any release there SHALL be exactly one IDLE cycle with gnt_o = 0 before the next grant (bubble).
REQ-020 last_idx SHALL update on grant, so a requester that was just served has the lowest priority.
REQ-021 With a single requester continuously active, it SHALL be re-granted every other cycle pair (grant, bubble).
REQ-022 Requests asserted or withdrawn during BUSY SHALL have no effect except per REQ-016.
REQ-023 gnt_o SHALL never have more than one bit set.

Reset
REQ-024 Asserting rst_n low SHALL immediately force IDLE, gnt_o = 0, busy_o = 0, timeout_o = 0, gnt_idx_o = 0, last_idx = N-1, and watchdog counter = 0, including mid-grant.
REQ-025 The first grant after reset SHALL favour requester 0.

Configuration
REQ-026 Macro DMA_RR_ARBITER_WATCHDOG_EN SHALL compile in a BUSY-cycle counter, cleared on grant.
REQ-027 With DMA_RR_ARBITER_WATCHDOG_EN defined, when the counter reaches TIMEOUT-1 in BUSY without done_i or an abandon, the arbiter SHALL release as per REQ-015 and pulse timeout_o for 1 cycle; a release from done_i in that same cycle SHALL take precedence with no pulse.
REQ-028 Without DMA_RR_ARBITER_WATCHDOG_EN, the counter SHALL be absent, timeout_o SHALL be tied 0, and TIMEOUT SHALL be unused.

Structure
REQ-029 Package netdma_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the watchdog counter width constant (16).
REQ-030 The one-hot grant SHALL be produced by instantiating the existing decoder sub-module with RANGE passed through.

Verification
REQ-031 After reset, req_i = 4'b1010: gnt_o = 4'b0010 one cycle later; hold until done_i, then 1 bubble, then gnt_o = 4'b1000.
REQ-032 req_i = 4'b1111 held, done_i pulsed 2 cycles after each grant: grant order 0, 1, 2, 3, 0 with a bubble between each.
REQ-033 Granted requester 2 drops req_i[2] mid-BUSY: gnt_o = 0 next cycle, and the next grant skips to requester 3 if it is requesting.
REQ-034 With the watchdog compiled in, TIMEOUT = 8 and no done_i: grant drops after 8 BUSY cycles and timeout_o pulses once; with done_i on the 8th cycle there is no pulse.
REQ-035 rst_n pulsed low during BUSY: gnt_o = 0 asynchronously; the next grant goes to the lowest-indexed active requester.
REQ-036 Random req_i/done_i for 10k cycles: gnt_o is always one-hot or zero, and no active requester waits more than N grants.
